// File: rtl/rst_seqr.sv
// rtl/rst_seqr.sv - ordered multi-stage reset release sequencer with ready tracking and sticky fault
module rst_seqr #(
  parameter int NUM_STAGES    = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_DELAY   = 8,
  parameter int READY_TIMEOUT = 1024,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_done,
  output logic                  fault,
  output logic [IDX_W-1:0]      fault_stage
);

  localparam int CMAX_HD = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CMAX    = (CMAX_HD > READY_TIMEOUT) ? CMAX_HD : READY_TIMEOUT;
  localparam int CNT_W   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  // HOLD ends one count later than the other states because its entry edge is the reset/request edge itself
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_END    = CNT_W'((READY_TIMEOUT > 0) ? READY_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {S_HOLD, S_DELAY, S_WAIT_RDY, S_DONE, S_FAULT} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [NUM_STAGES-1:0]   stage_rst_n;
  logic                    all_done_n, fault_n, ack_n;
  logic [IDX_W-1:0]        fault_stage_n;
  logic [NUM_STAGES-1:0]   loss_mask;
  logic [IDX_W-1:0]        loss_idx;
  logic                    loss_any;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= S_HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      all_done    <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
      sw_rst_ack  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      stage_rst   <= stage_rst_n;
      all_done    <= all_done_n;
      fault       <= fault_n;
      fault_stage <= fault_stage_n;
      sw_rst_ack  <= ack_n;
    end
  end

  // The stage currently being waited on is released but not yet up, so it is not a ready loss
  always_comb begin
    loss_mask = ~stage_rst & ~stage_ready;
    if (state == S_WAIT_RDY) loss_mask[idx] = 1'b0;
    loss_any = (state == S_DELAY || state == S_WAIT_RDY || state == S_DONE) && (|loss_mask);
    loss_idx = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (loss_mask[j]) loss_idx = IDX_W'(j);
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    stage_rst_n   = stage_rst;
    all_done_n    = 1'b0;
    fault_n       = fault;
    fault_stage_n = fault_stage;
    ack_n         = 1'b0;

    if (sw_rst_req) begin
      state_n       = S_HOLD;
      cnt_n         = '0;
      idx_n         = '0;
      stage_rst_n   = '1;
      fault_n       = 1'b0;
      fault_stage_n = '0;
      ack_n         = 1'b1;
    end else if (loss_any) begin
      state_n       = S_FAULT;
      cnt_n         = '0;
      stage_rst_n   = '1;
      fault_n       = 1'b1;
      fault_stage_n = loss_idx;
    end else begin
      case (state)
        S_HOLD: begin
          stage_rst_n = '1;
          if (cnt == HOLD_END) begin
            state_n = S_DELAY;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_DELAY: begin
          if (cnt == DELAY_END) begin
            state_n          = S_WAIT_RDY;
            cnt_n            = '0;
            stage_rst_n[idx] = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT_RDY: begin
          if (stage_ready[idx]) begin
            cnt_n = '0;
            if (idx == LAST_IDX) begin
              state_n    = S_DONE;
              all_done_n = 1'b1;
            end else begin
              state_n = S_DELAY;
              idx_n   = idx + 1'b1;
            end
          end else if (READY_TIMEOUT > 0) begin
            if (cnt == TO_END) begin
              state_n       = S_FAULT;
              cnt_n         = '0;
              stage_rst_n   = '1;
              fault_n       = 1'b1;
              fault_stage_n = idx;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          all_done_n = 1'b1;
        end
        S_FAULT: begin
          stage_rst_n = '1;
          fault_n     = 1'b1;
        end
        default: begin
          state_n     = S_HOLD;
          cnt_n       = '0;
          stage_rst_n = '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seqr.sv
// tb/tb_rst_seqr.sv - scoreboard bench for rst_seqr: expected output changes queued by stimulus, checked by monitor
module tb_rst_seqr;

  logic       clk;
  logic       sync_rst;
  logic [3:0] stage_ready;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [3:0] stage_rst;
  logic       all_done;
  logic       fault;
  logic [1:0] fault_stage;

  rst_seqr #(
    .NUM_STAGES   (4),
    .HOLD_CYCLES  (16),
    .STAGE_DELAY  (8),
    .READY_TIMEOUT(32)
  ) dut (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .stage_ready(stage_ready),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .stage_rst  (stage_rst),
    .all_done   (all_done),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {ack, fault, fault_stage[1:0], all_done, stage_rst[3:0]}
  logic [8:0] outs;
  assign outs = {sw_rst_ack, fault, fault_stage, all_done, stage_rst};

  typedef struct {
    int         at;
    logic [8:0] val;
    int         tag;
  } ev_t;

  ev_t  q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   tag_ctr = 0;
  logic mon_en  = 1'b0;

  task automatic exp_at(input int at, input logic [8:0] val);
    ev_t e;
    e.at  = at;
    e.val = val;
    e.tag = tag_ctr;
    tag_ctr++;
    q.push_back(e);
  endtask

  task automatic push_seq(input int e0);
    exp_at(e0 + 24, 9'b0_0_00_0_1110);
    exp_at(e0 + 33, 9'b0_0_00_0_1100);
    exp_at(e0 + 42, 9'b0_0_00_0_1000);
    exp_at(e0 + 51, 9'b0_0_00_0_0000);
    exp_at(e0 + 52, 9'b0_0_00_1_0000);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin : monitor
    logic [8:0] prev;
    ev_t        e;
    wait (mon_en);
    prev = outs;
    forever begin
      @(negedge clk);
      if (outs !== prev) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, outs);
        end else begin
          e = q.pop_front();
          if (cyc == e.at && outs === e.val)
            n_pass++;
          else
            $display("FAIL ev%0d got cyc=%0d outs=%b want cyc=%0d outs=%b", e.tag, cyc, outs, e.at, e.val);
        end
        prev = outs;
      end
    end
  end

  initial begin : stim
    int s;
    int r;
    int e0;
    sync_rst    = 1'b1;
    stage_ready = 4'hF;
    sw_rst_req  = 1'b0;
    repeat (3) @(negedge clk);

    n_total++;
    if (outs === 9'b0_0_00_0_1111) n_pass++;
    else $display("FAIL reset_state got=%b want=%b", outs, 9'b0_0_00_0_1111);
    mon_en = 1'b1;

    // normal bring-up from sync_rst release
    sync_rst = 1'b0;
    e0 = cyc + 1;
    push_seq(e0);
    wait_until(e0 + 55);

    // two ready losses in DONE, lowest index reported
    stage_ready = 4'b0101;
    exp_at(cyc + 1, 9'b0_1_01_0_1111);
    wait_until(cyc + 4);
    stage_ready = 4'hF;

    // one-cycle software request out of FAULT replays the sequence
    sw_rst_req = 1'b1;
    s = cyc + 1;
    exp_at(s, 9'b1_0_00_0_1111);
    exp_at(s + 1, 9'b0_0_00_0_1111);
    push_seq(s + 1);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(s + 57);

    // software request and ready loss on the same cycle: request wins
    sw_rst_req  = 1'b1;
    stage_ready = 4'b1011;
    s = cyc + 1;
    exp_at(s, 9'b1_0_00_0_1111);
    exp_at(s + 1, 9'b0_0_00_0_1111);
    push_seq(s + 1);
    @(negedge clk);
    sw_rst_req  = 1'b0;
    stage_ready = 4'hF;
    wait_until(s + 58);

    // stage 2 never ready: timeout 32 cycles after its WAIT_RDY entry
    sw_rst_req  = 1'b1;
    stage_ready = 4'b1011;
    s = cyc + 1;
    exp_at(s, 9'b1_0_00_0_1111);
    exp_at(s + 1, 9'b0_0_00_0_1111);
    exp_at(s + 25, 9'b0_0_00_0_1110);
    exp_at(s + 34, 9'b0_0_00_0_1100);
    exp_at(s + 43, 9'b0_0_00_0_1000);
    exp_at(s + 75, 9'b0_1_10_0_1111);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(s + 80);
    stage_ready = 4'hF;

    // sync_rst during stage 2 DELAY aborts, then a clean restart
    sw_rst_req = 1'b1;
    s = cyc + 1;
    exp_at(s, 9'b1_0_00_0_1111);
    exp_at(s + 1, 9'b0_0_00_0_1111);
    exp_at(s + 25, 9'b0_0_00_0_1110);
    exp_at(s + 34, 9'b0_0_00_0_1100);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(s + 38);
    sync_rst = 1'b1;
    r = cyc + 1;
    exp_at(r, 9'b0_0_00_0_1111);
    wait_until(r + 1);
    sync_rst = 1'b0;
    e0 = cyc + 1;
    push_seq(e0);
    wait_until(e0 + 58);

    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL missing_events got=%0d pending want=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
